// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iir_pkg
// Purpose  : Shared sample types and the round-half-up / saturate quantiser.
// Revision : 1.0  initial release
// ============================================================================
package iir_pkg;

  localparam int c_ndint  = 3;
  localparam int c_ndfrac = 22;
  localparam int c_noint  = 1;
  localparam int c_nofrac = 15;
  localparam int c_no     = c_noint + c_nofrac;

  localparam logic [c_no-1:0] OMAX = {1'b0, {(c_no-1){1'b1}}};
  localparam logic [c_no-1:0] OMIN = {1'b1, {(c_no-1){1'b0}}};

  typedef logic signed [c_ndint-1:-c_ndfrac] din_t;
  typedef logic signed [c_noint-1:-c_nofrac] dout_t;

  typedef struct packed {
    logic        sat;
    logic [63:0] word;
  } qres_t;

  // The low ndint+ndfrac bits of value hold the sample; the result word is
  // sign-extended to 64 bits and the caller keeps the low noint+nofrac bits.
  function automatic qres_t round_sat(input logic [63:0] value,
                                      input int ndint, input int ndfrac,
                                      input int noint, input int nofrac);
    logic signed [63:0] v;
    logic signed [63:0] sum;
    logic signed [63:0] q;
    logic signed [63:0] vmax;
    logic signed [63:0] vmin;
    int                 sh;
    qres_t              r;
    sh   = 64 - ndint - ndfrac;
    v    = signed'(value) <<< sh;
    v    = v >>> sh;
    sum  = v + (64'sd1 <<< (ndfrac - nofrac - 1));
    q    = sum >>> (ndfrac - nofrac);
    vmax = (64'sd1 <<< (noint + nofrac - 1)) - 64'sd1;
    vmin = -vmax - 64'sd1;
    r.sat  = 1'b0;
    r.word = q;
    if (q > vmax) begin
      r.sat  = 1'b1;
      r.word = vmax;
    end else if (q < vmin) begin
      r.sat  = 1'b1;
      r.word = vmin;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_fwft
// Purpose  : Single-clock first-word-fall-through FIFO with occupancy count.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_cw-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == c_cw'(DEPTH));
  assign w_pop   = rd_en && !empty;
  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign w_push  = wr_en && (!full || w_pop);
  assign rd_data = r_mem[r_rptr];
  assign count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/iir_decim_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iir_decim_fifo
// Purpose  : Keep every R-th filter sample, round/saturate it, buffer it in a
//            FWFT FIFO and present it on a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module iir_decim_fifo
  import iir_pkg::*;
#(
  parameter int Ndint  = 3,
  parameter int Ndfrac = 22,
  parameter int Noint  = 1,
  parameter int Nofrac = 15,
  parameter int R      = 4,
  parameter int DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dv_in,
  input  logic signed [Ndint-1:-Ndfrac] d_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [Noint-1:-Nofrac] m_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          sat,
  output logic                          ovf
);

  localparam int c_no = Noint + Nofrac;
  localparam int c_pw = (R > 1) ? $clog2(R) : 1;

  logic [c_pw-1:0] r_phase;
  logic            r_q_valid;
  logic [c_no-1:0] r_q_data;
  logic            r_sat;
  logic            r_ovf;

  logic            w_keep;
  qres_t           w_q;
  logic            w_unused_hi;
  logic            w_rd;
  logic            w_empty;
  logic            w_full;
  logic [c_no-1:0] w_head;

  assign w_keep      = dv_in && (r_phase == '0);
  assign w_q         = round_sat(64'(d_in), Ndint, Ndfrac, Noint, Nofrac);
  assign w_unused_hi = ^w_q.word[63:c_no];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (dv_in) begin
      if (r_phase == c_pw'(R - 1)) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_valid <= 1'b0;
      r_q_data  <= '0;
      r_sat     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_q_valid <= w_keep;
      if (w_keep) begin
        r_q_data <= w_q.word[c_no-1:0];
      end
      r_sat <= r_sat | (w_keep & w_q.sat);
      // Drop only when no pop frees a slot this edge.
      r_ovf <= r_ovf | (r_q_valid & w_full & ~w_rd);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (c_no),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_q_valid),
    .wr_data (r_q_data),
    .rd_en   (w_rd),
    .rd_data (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .count   (count)
  );

  assign m_valid = !w_empty;
  assign w_rd    = m_valid && m_ready;
  assign m_data  = m_valid ? w_head : '0;
  assign sat     = r_sat;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire
